chip_gate_checker: RTL and testbench
====================================

# chip_gate_checker

Parametrised successor to the single-gate 7400-series checkers. It exercises every gate of a quad (or N-way) 2-input logic chip in parallel, with a runtime-selectable gate function, and a programmable settle delay before each sample. It accumulates a per-gate failure mask and reports the first failing vector. It sits between the chip-select mux and the result display, and uses the same Run / Done / RSLT / DISP_RSLT handshake as the existing checkers.

## Interface
- NUM_GATES, 4: number of 2-input gates on the device under test; legal range 1..8.
- SETTLE_CYCLES, 2: cycles each vector is driven before Sense_Y is sampled; legal range 1..255.
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low. Reset=0 immediately forces the idle state and the reset values below.
- Run  in  1  start request; sampled only in Halted.
- Gate_Sel  in  3  gate function: 0 NAND, 1 NOR, 2 AND, 3 OR, 4 XOR, 5 XNOR; 6 and 7 are invalid. Latched in Set.
- Drive_A  out  NUM_GATES  input A to each gate.
- Drive_B  out  NUM_GATES  input B to each gate.
- Sense_Y  in  NUM_GATES  output Y of each gate, read from the chip.
- DISP_RSLT  in  1  result acknowledge; releases Done_s.
- Busy  out  1  high in every state except Halted and Done_s.
- Done  out  1  high while the FSM is in Done_s.
- RSLT  out  1  1 = all gates passed every vector.
- Fail_Mask  out  NUM_GATES  bit i = 1 if gate i mismatched on any vector.
- Fail_Vec  out  2  index {A,B} of the first vector on which any gate mismatched; 0 if none.
- Sel_Err  out  1  the latched Gate_Sel was invalid.

## Operation
- States: Halted, Set, Settle, Sample, Done_s.
- Halted
  - Run=1 moves the FSM to Set; otherwise it stays in Halted.
  - Run is ignored in every other state.
- Set, one cycle:
  - Latch Gate_Sel.
  - Clear Fail_Mask, Fail_Vec and Sel_Err; set RSLT=1.
  - Set vector index vec=0 and the settle counter cnt=0.
  - If Gate_Sel is 6 or 7: set Sel_Err=1, RSLT=0, Fail_Mask=all ones, and go straight to Done_s.
  - Otherwise go to Settle.
- Settle
  - Drive_A={NUM_GATES{vec[1]}}, Drive_B={NUM_GATES{vec[0]}}.
  - cnt increments each cycle. When cnt==SETTLE_CYCLES-1: clear cnt and go to Sample.
- Sample, one cycle:
  - Drives are held at the current vector.
  - Compute expected Y = f(vec[1],vec[0]) from the latched function.
  - mism = Sense_Y XOR {NUM_GATES{expected}}.
  - Fail_Mask |= mism. If mism≠0 and no earlier failure was recorded: Fail_Vec=vec and RSLT=0.
  - If vec==3 go to Done_s; else vec+1 and go to Settle.
- Vector order: 00, 01, 10, 11. vec is 2 bits and never wraps during a run.
- Done_s
  - Done=1; drives are 0.
  - DISP_RSLT=1 moves the FSM to Halted; otherwise it stays in Done_s.
- RSLT, Fail_Mask, Fail_Vec and Sel_Err hold their values through Halted until the next Set.
- Drive_A and Drive_B are 0 in Halted, Set and Done_s.
- Drives are decoded from registered state and vec only; there is no combinational path from any input.

## Timing
- Reset values: all outputs are 0 (Busy, Done, RSLT, Fail_Mask, Fail_Vec, Sel_Err, Drive_A, Drive_B); State=Halted.
- Let the Run-sampling edge be E0:
  - Set occupies the cycle after E0.
  - Settle is entered at E1.
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - Done_s is entered at E(1+4·(SETTLE_CYCLES+1)), i.e. E13 for SETTLE_CYCLES=2.
  - With an invalid Gate_Sel, Done_s is entered at E1.
- Sense_Y is sampled only on the rising edge that ends a Sample cycle. Values at any other time are don't-care.
- Run and DISP_RSLT both high in Halted: Run wins and the FSM goes to Set.
- DISP_RSLT held high across Done_s→Halted causes no further effect.
- Reset asserted mid-run: the FSM aborts immediately and drives go to 0 asynchronously. Results are cleared, not held.

## Test plan
- NAND, model-correct Sense_Y, NUM_GATES=4, SETTLE_CYCLES=2 -> Done at E13; RSLT=1, Fail_Mask=0000, Fail_Vec=0. Drives step 00,01,10,11, each held 3 cycles.
- NOR selected while the chip model behaves as NAND -> RSLT=0, Fail_Mask=1111, Fail_Vec=01 (first mismatch is on vector 01).
- XOR with gate 2's output stuck at 1 -> RSLT=0, Fail_Mask=0100, Fail_Vec=00.
- Gate_Sel=7 -> Done at E1; Sel_Err=1, RSLT=0, Fail_Mask=1111, drives stay 0.
- Reset pulled low during the Settle of vector 10 -> all outputs 0 immediately. After release, Run performs a full fresh pass with the correct RSLT.
- Run pulsed mid-test, DISP_RSLT withheld for 20 cycles -> the pulse is ignored and Done stays high throughout. DISP_RSLT=1 returns the FSM to Halted next edge with RSLT and Fail_Mask retained.

Source files
------------

// File: rtl/chip_gate_checker_if.sv
// Bundle of the checker's handshake, chip-drive and result signals.
// The host (master) issues Run/Gate_Sel/DISP_RSLT and returns Sense_Y from the chip.
interface chip_gate_checker_if #(
    parameter int NUM_GATES = 4
);
    logic                 Run;
    logic [2:0]           Gate_Sel;
    logic [NUM_GATES-1:0] Drive_A;
    logic [NUM_GATES-1:0] Drive_B;
    logic [NUM_GATES-1:0] Sense_Y;
    logic                 DISP_RSLT;
    logic                 Busy;
    logic                 Done;
    logic                 RSLT;
    logic [NUM_GATES-1:0] Fail_Mask;
    logic [1:0]           Fail_Vec;
    logic                 Sel_Err;

    modport master (
        output Run, Gate_Sel, Sense_Y, DISP_RSLT,
        input  Drive_A, Drive_B, Busy, Done, RSLT, Fail_Mask, Fail_Vec, Sel_Err
    );

    modport slave (
        input  Run, Gate_Sel, Sense_Y, DISP_RSLT,
        output Drive_A, Drive_B, Busy, Done, RSLT, Fail_Mask, Fail_Vec, Sel_Err
    );
endinterface

// File: rtl/chip_gate_checker.sv
// Exercises all gates of an N-way 2-input logic chip through the four {A,B}
// vectors, with a settle delay before each sample, and accumulates failures.
module chip_gate_checker #(
    parameter int NUM_GATES     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 Clk,
    input logic                 Reset,
    chip_gate_checker_if.slave  bus
);
    typedef enum logic [2:0] {
        HALTED,
        SET,
        SETTLE,
        SAMPLE,
        DONE_S
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t               state_reg, state_next;
    logic [2:0]           sel_reg, sel_next;
    logic [1:0]           vec_reg, vec_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic                 rslt_reg, rslt_next;
    logic [NUM_GATES-1:0] mask_reg, mask_next;
    logic [1:0]           fvec_reg, fvec_next;
    logic                 sel_err_reg, sel_err_next;

    logic                 expected;
    logic                 drive_en;
    logic [NUM_GATES-1:0] mism;
    logic [NUM_GATES-1:0] drive_a;
    logic [NUM_GATES-1:0] drive_b;

    // Reference output of the selected function for the current vector.
    always_comb begin
        expected = 1'b0;
        case (sel_reg)
            3'd0:    expected = ~(vec_reg[1] & vec_reg[0]);
            3'd1:    expected = ~(vec_reg[1] | vec_reg[0]);
            3'd2:    expected = vec_reg[1] & vec_reg[0];
            3'd3:    expected = vec_reg[1] | vec_reg[0];
            3'd4:    expected = vec_reg[1] ^ vec_reg[0];
            3'd5:    expected = ~(vec_reg[1] ^ vec_reg[0]);
            default: expected = 1'b0;
        endcase
    end

    // Drives come only from registered state so the chip never sees input glitches.
    assign drive_en = (state_reg == SETTLE) || (state_reg == SAMPLE);

    generate
        for (genvar gi = 0; gi < NUM_GATES; gi++) begin : g_gate
            assign drive_a[gi] = drive_en & vec_reg[1];
            assign drive_b[gi] = drive_en & vec_reg[0];
            assign mism[gi]    = bus.Sense_Y[gi] ^ expected;
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        vec_next     = vec_reg;
        cnt_next     = cnt_reg;
        rslt_next    = rslt_reg;
        mask_next    = mask_reg;
        fvec_next    = fvec_reg;
        sel_err_next = sel_err_reg;
        case (state_reg)
            HALTED: begin
                if (bus.Run) state_next = SET;
            end
            SET: begin
                sel_next     = bus.Gate_Sel;
                mask_next    = '0;
                fvec_next    = 2'd0;
                sel_err_next = 1'b0;
                rslt_next    = 1'b1;
                vec_next     = 2'd0;
                cnt_next     = 8'd0;
                if (bus.Gate_Sel[2:1] == 2'b11) begin
                    sel_err_next = 1'b1;
                    rslt_next    = 1'b0;
                    mask_next    = '1;
                    state_next   = DONE_S;
                end else begin
                    state_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = SAMPLE;
                end else begin
                    cnt_next   = cnt_reg + 8'd1;
                end
            end
            SAMPLE: begin
                mask_next = mask_reg | mism;
                // Mask is cleared at start and only grows, so empty means no prior failure.
                if ((mism != '0) && (mask_reg == '0)) begin
                    fvec_next = vec_reg;
                    rslt_next = 1'b0;
                end
                if (vec_reg == 2'd3) begin
                    state_next = DONE_S;
                end else begin
                    vec_next   = vec_reg + 2'd1;
                    state_next = SETTLE;
                end
            end
            DONE_S: begin
                if (bus.DISP_RSLT) state_next = HALTED;
            end
            default: state_next = HALTED;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= HALTED;
            sel_reg     <= 3'd0;
            vec_reg     <= 2'd0;
            cnt_reg     <= 8'd0;
            rslt_reg    <= 1'b0;
            mask_reg    <= '0;
            fvec_reg    <= 2'd0;
            sel_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            vec_reg     <= vec_next;
            cnt_reg     <= cnt_next;
            rslt_reg    <= rslt_next;
            mask_reg    <= mask_next;
            fvec_reg    <= fvec_next;
            sel_err_reg <= sel_err_next;
        end
    end

    assign bus.Drive_A   = drive_a;
    assign bus.Drive_B   = drive_b;
    assign bus.Busy      = (state_reg == SET) || (state_reg == SETTLE) || (state_reg == SAMPLE);
    assign bus.Done      = (state_reg == DONE_S);
    assign bus.RSLT      = rslt_reg;
    assign bus.Fail_Mask = mask_reg;
    assign bus.Fail_Vec  = fvec_reg;
    assign bus.Sel_Err   = sel_err_reg;
endmodule

// File: tb/tb_chip_gate_checker.sv
// Directed bench for chip_gate_checker: a behavioural chip with stuck-at faults,
// a vector table of full passes, and hand sequences for reset/handshake corners.
module tb_chip_gate_checker;
    localparam int NG  = 4;
    localparam int SC  = 2;
    localparam int LAT = 1 + 4 * (SC + 1);

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    chip_gate_checker_if #(.NUM_GATES(NG)) bus();

    chip_gate_checker #(.NUM_GATES(NG), .SETTLE_CYCLES(SC)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [2:0]    chip_fn;
    logic [NG-1:0] stuck1;
    logic [NG-1:0] stuck0;
    logic [NG-1:0] sense;

    function automatic logic gate_f(input logic [2:0] fn, input logic a, input logic b);
        case (fn)
            3'd0:    return ~(a & b);
            3'd1:    return ~(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural chip: the chosen function per gate plus stuck-at-1/0 faults.
    always_comb begin
        sense = '0;
        for (int i = 0; i < NG; i++)
            sense[i] = (gate_f(chip_fn, bus.Drive_A[i], bus.Drive_B[i]) | stuck1[i]) & ~stuck0[i];
    end
    assign bus.Sense_Y = sense;

    typedef struct {
        logic [2:0]    sel;
        logic [2:0]    chip;
        logic [NG-1:0] s1;
        logic [NG-1:0] s0;
        logic          rslt;
        logic [NG-1:0] mask;
        logic [1:0]    fvec;
        logic          serr;
        int            lat;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic configure(input logic [2:0] sel, input logic [2:0] fn,
                             input logic [NG-1:0] s1, input logic [NG-1:0] s0);
        @(negedge Clk);
        bus.Gate_Sel = sel;
        chip_fn      = fn;
        stuck1       = s1;
        stuck0       = s0;
    endtask

    // Pulse Run for the sampling edge E0; returns n such that Done appears at En (0 = timeout).
    task automatic start_and_wait(output int lat);
        @(negedge Clk);
        bus.Run = 1'b1;
        @(posedge Clk);
        #1 bus.Run = 1'b0;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clk);
            #1;
            if (bus.Done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic ack(input string tag, input logic exp_rslt, input logic [NG-1:0] exp_mask);
        @(negedge Clk);
        bus.DISP_RSLT = 1'b1;
        @(posedge Clk);
        #1;
        chk({tag, "_ack_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_ack_rslt"}, 32'(bus.RSLT), 32'(exp_rslt));
        chk({tag, "_ack_mask"}, 32'(bus.Fail_Mask), 32'(exp_mask));
        @(negedge Clk);
        bus.DISP_RSLT = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [1:0]  v;
        logic [NG-1:0] rep1;
        logic [NG-1:0] rep0;

        Reset         = 1'b0;
        bus.Run       = 1'b0;
        bus.Gate_Sel  = 3'd0;
        bus.DISP_RSLT = 1'b0;
        chip_fn       = 3'd0;
        stuck1        = '0;
        stuck0        = '0;

        //           sel   chip  s1     s0     rslt  mask   fvec   serr  lat
        tbl[0] = '{3'd0, 3'd0, 4'h0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, LAT};
        tbl[1] = '{3'd1, 3'd0, 4'h0, 4'h0, 1'b0, 4'hF, 2'd1, 1'b0, LAT};
        tbl[2] = '{3'd4, 3'd4, 4'h4, 4'h0, 1'b0, 4'h4, 2'd0, 1'b0, LAT};
        tbl[3] = '{3'd7, 3'd0, 4'h0, 4'h0, 1'b0, 4'hF, 2'd0, 1'b1, 1};
        tbl[4] = '{3'd6, 3'd6, 4'h0, 4'h0, 1'b0, 4'hF, 2'd0, 1'b1, 1};
        tbl[5] = '{3'd2, 3'd2, 4'h0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, LAT};
        tbl[6] = '{3'd3, 3'd3, 4'h0, 4'h1, 1'b0, 4'h1, 2'd1, 1'b0, LAT};
        tbl[7] = '{3'd5, 3'd5, 4'h0, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, LAT};
        tbl[8] = '{3'd5, 3'd0, 4'h0, 4'h0, 1'b0, 4'hF, 2'd1, 1'b0, LAT};
        tbl[9] = '{3'd2, 3'd2, 4'h8, 4'h0, 1'b0, 4'h8, 2'd0, 1'b0, LAT};

        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_rslt", 32'(bus.RSLT), 32'd0);
        chk("rst_mask", 32'(bus.Fail_Mask), 32'd0);
        chk("rst_fvec", 32'(bus.Fail_Vec), 32'd0);
        chk("rst_serr", 32'(bus.Sel_Err), 32'd0);
        chk("rst_drv", 32'({bus.Drive_A, bus.Drive_B}), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            configure(tbl[i].sel, tbl[i].chip, tbl[i].s1, tbl[i].s0);
            start_and_wait(lat);
            chk($sformatf("t%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("t%0d_rslt", i), 32'(bus.RSLT), 32'(tbl[i].rslt));
            chk($sformatf("t%0d_mask", i), 32'(bus.Fail_Mask), 32'(tbl[i].mask));
            chk($sformatf("t%0d_fvec", i), 32'(bus.Fail_Vec), 32'(tbl[i].fvec));
            chk($sformatf("t%0d_serr", i), 32'(bus.Sel_Err), 32'(tbl[i].serr));
            chk($sformatf("t%0d_busy", i), 32'(bus.Busy), 32'd0);
            chk($sformatf("t%0d_drv", i), 32'({bus.Drive_A, bus.Drive_B}), 32'd0);
            $display("vector %0d: sel=%0d chip=%0d lat=%0d rslt=%0b mask=%b fvec=%0d serr=%0b",
                     i, tbl[i].sel, tbl[i].chip, lat, bus.RSLT, bus.Fail_Mask, bus.Fail_Vec, bus.Sel_Err);
            ack($sformatf("t%0d", i), tbl[i].rslt, tbl[i].mask);
        end

        // Drive trace of a NAND pass: each vector held SC+1 cycles, 00,01,10,11.
        configure(3'd0, 3'd0, '0, '0);
        @(negedge Clk);
        bus.Run = 1'b1;
        @(posedge Clk);
        #1 bus.Run = 1'b0;
        chk("trace_set_busy", 32'(bus.Busy), 32'd1);
        chk("trace_set_drv", 32'({bus.Drive_A, bus.Drive_B}), 32'd0);
        for (int k = 1; k <= LAT; k++) begin
            @(posedge Clk);
            #1;
            if (k < LAT) begin
                v    = 2'((k - 1) / (SC + 1));
                rep1 = {NG{v[1]}};
                rep0 = {NG{v[0]}};
                chk($sformatf("trace_e%0d_a", k), 32'(bus.Drive_A), 32'(rep1));
                chk($sformatf("trace_e%0d_b", k), 32'(bus.Drive_B), 32'(rep0));
                chk($sformatf("trace_e%0d_busy", k), 32'(bus.Busy), 32'd1);
            end else begin
                chk("trace_done", 32'(bus.Done), 32'd1);
                chk("trace_done_drv", 32'({bus.Drive_A, bus.Drive_B}), 32'd0);
            end
        end
        $display("trace: NAND drive sequence walked to Done");
        ack("trace", 1'b1, 4'h0);

        // Reset during the Settle of vector 10, then a fresh pass.
        configure(3'd0, 3'd0, '0, '0);
        @(negedge Clk);
        bus.Run = 1'b1;
        @(posedge Clk);
        #1 bus.Run = 1'b0;
        repeat (7) @(posedge Clk);
        #1;
        chk("midrst_pre_a", 32'(bus.Drive_A), 32'hF);
        chk("midrst_pre_b", 32'(bus.Drive_B), 32'h0);
        Reset = 1'b0;
        #1;
        chk("midrst_drv", 32'({bus.Drive_A, bus.Drive_B}), 32'd0);
        chk("midrst_busy", 32'(bus.Busy), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        chk("midrst_rslt", 32'(bus.RSLT), 32'd0);
        chk("midrst_mask", 32'(bus.Fail_Mask), 32'd0);
        chk("midrst_serr", 32'(bus.Sel_Err), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        start_and_wait(lat);
        chk("postrst_lat", 32'(lat), 32'(LAT));
        chk("postrst_rslt", 32'(bus.RSLT), 32'd1);
        $display("reset: mid-run abort then fresh pass lat=%0d rslt=%0b", lat, bus.RSLT);
        ack("postrst", 1'b1, 4'h0);

        // Run+DISP_RSLT together in Halted start a run; a mid-run Run pulse is ignored.
        configure(3'd4, 3'd4, 4'h4, '0);
        @(negedge Clk);
        bus.Run       = 1'b1;
        bus.DISP_RSLT = 1'b1;
        @(posedge Clk);
        #1;
        bus.Run       = 1'b0;
        bus.DISP_RSLT = 1'b0;
        chk("both_busy", 32'(bus.Busy), 32'd1);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clk);
            #1;
            bus.Run = (n == 5);
            if (bus.Done) begin
                lat = n;
                break;
            end
        end
        bus.Run = 1'b0;
        chk("both_lat", 32'(lat), 32'(LAT));
        chk("both_mask", 32'(bus.Fail_Mask), 32'h4);
        chk("both_fvec", 32'(bus.Fail_Vec), 32'd0);

        // DISP_RSLT withheld for 20 cycles with stray Run pulses.
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            bus.Run = (n % 3 == 0);
            @(posedge Clk);
            #1;
            chk($sformatf("hold_done_%0d", n), 32'(bus.Done), 32'd1);
        end
        @(negedge Clk);
        bus.Run       = 1'b0;
        bus.DISP_RSLT = 1'b1;
        @(posedge Clk);
        #1;
        chk("release_done", 32'(bus.Done), 32'd0);
        chk("release_busy", 32'(bus.Busy), 32'd0);
        chk("release_rslt", 32'(bus.RSLT), 32'd0);
        chk("release_mask", 32'(bus.Fail_Mask), 32'h4);
        repeat (3) @(posedge Clk);
        #1;
        chk("disp_held_busy", 32'(bus.Busy), 32'd0);
        chk("disp_held_done", 32'(bus.Done), 32'd0);
        chk("disp_held_mask", 32'(bus.Fail_Mask), 32'h4);
        @(negedge Clk);
        bus.DISP_RSLT = 1'b0;
        $display("handshake: Run ignored in Done_s, results retained after release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
